nec_ir_tx: RTL and testbench

NEC-protocol infrared transmitter: accepts a 32-bit command word over a valid/ready handshake and emits the complete NEC frame as a carrier-modulated drive signal for an IR LED. This is the sending end of the link whose decoded `ir_command`/`ir_data_ready` output drives the robot's control logic. The bench remote-emulator and the board-to-board test rig use it to inject POWER, PLAY, MUTE, difficulty and follow-distance commands.

---
 rtl/nec_ir_pkg.sv | 20 ++
 rtl/ir_carrier_gen.sv | 29 ++
 rtl/nec_ir_tx.sv | 82 ++++++++
 tb/tb_nec_ir_tx.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/nec_ir_pkg.sv
// nec_ir_pkg: shared NEC transmitter states, segment lengths and remote command codes.
package nec_ir_pkg;
  typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP} state_t;
  localparam int LEAD_MARK_UNITS  = 16;
  localparam int LEAD_SPACE_UNITS = 8;
  localparam int ZERO_SPACE_UNITS = 1;
  localparam int ONE_SPACE_UNITS  = 3;
  localparam int STOP_UNITS       = 1;
  localparam logic [31:0] CMD_POWER = 32'hed126b86;
  localparam logic [31:0] CMD_PLAY  = 32'he9166b86;
  localparam logic [31:0] CMD_MUTE  = 32'hf30c6b86;
  localparam logic [31:0] CMD_CH_UP = 32'he51a6b86;
  // BIT_MARK and STOP_MARK both fall through to the single-unit default.
  function automatic logic [6:0] seg_units(input state_t s, input logic one, input logic [6:0] gap);
    return s == LEAD_MARK  ? 7'(LEAD_MARK_UNITS) :
           s == LEAD_SPACE ? 7'(LEAD_SPACE_UNITS) :
           s == BIT_SPACE  ? (one ? 7'(ONE_SPACE_UNITS) : 7'(ZERO_SPACE_UNITS)) :
           s == GAP        ? gap : 7'(STOP_UNITS);
  endfunction
endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: 50% duty carrier phase, restarted high at the start of every mark.
module ir_carrier_gen #(
  parameter int CARRIER_HALF = 657
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic phase
);
  localparam int CW = $clog2(CARRIER_HALF + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic phase_q, phase_d, half_end;
  always_comb begin
    half_end = cnt_q == CW'(CARRIER_HALF - 1);
    cnt_d    = (restart || !enable || half_end) ? '0 : cnt_q + 1'b1;
    phase_d  = restart ? 1'b1 : !enable ? 1'b0 : half_end ? !phase_q : phase_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
  assign phase = phase_q;
endmodule

// File: rtl/nec_ir_tx.sv
// nec_ir_tx: NEC infrared frame transmitter with valid/ready command input and carrier-modulated LED drive.
module nec_ir_tx
  import nec_ir_pkg::*;
#(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 657,
  parameter int GAP_UNITS    = 72
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] command,
  input  logic        send,
  output logic        ready,
  output logic        envelope,
  output logic        ir_out,
  output logic        frame_done
);
  localparam int UW = $clog2(UNIT_CYCLES);
  state_t state_q, state_d;
  logic [UW-1:0] unit_q, unit_d;
  logic [6:0] seg_q, seg_d;
  logic [4:0] bit_q, bit_d;
  logic [31:0] sh_q, sh_d;
  logic ready_q, env_q, done_q, unit_end, seg_end, mark_d, restart, phase;
  always_comb begin
    unit_end = unit_q == UW'(UNIT_CYCLES - 1);
    seg_end  = unit_end && seg_q == seg_units(state_q, sh_q[0], 7'(GAP_UNITS)) - 7'd1;
    unit_d   = (state_q == IDLE || unit_end) ? '0 : unit_q + 1'b1;
    seg_d    = (state_q == IDLE || seg_end) ? '0 : seg_q + 7'(unit_end);
    state_d  = state_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    case (state_q)
      IDLE: if (send && ready_q) begin
        state_d = LEAD_MARK;
        sh_d    = command;
        bit_d   = '0;
      end
      LEAD_MARK:  if (seg_end) state_d = LEAD_SPACE;
      LEAD_SPACE: if (seg_end) state_d = BIT_MARK;
      BIT_MARK:   if (seg_end) state_d = BIT_SPACE;
      BIT_SPACE: if (seg_end) begin
        state_d = bit_q == 5'd31 ? STOP_MARK : BIT_MARK;
        bit_d   = bit_q == 5'd31 ? bit_q : bit_q + 5'd1;
        sh_d    = sh_q >> 1;
      end
      STOP_MARK:  if (seg_end) state_d = GAP;
      GAP:        if (seg_end) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    mark_d  = state_d inside {LEAD_MARK, BIT_MARK, STOP_MARK};
    restart = mark_d && state_d != state_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      unit_q  <= '0;
      seg_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      ready_q <= 1'b1;
      env_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      seg_q   <= seg_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      ready_q <= state_d == IDLE;
      env_q   <= mark_d;
      done_q  <= state_q == STOP_MARK && seg_end;
    end
  end
  ir_carrier_gen #(.CARRIER_HALF(CARRIER_HALF)) u_carrier (
    .clk(clk), .reset(reset), .restart(restart), .enable(mark_d), .phase(phase)
  );
  assign ready      = ready_q;
  assign envelope   = env_q;
  assign ir_out     = env_q & phase;
  assign frame_done = done_q;
endmodule

// File: tb/tb_nec_ir_tx.sv
// tb_nec_ir_tx: randomized frame checks of nec_ir_tx against a per-cycle waveform model built from NEC segment rules.
module tb_nec_ir_tx;
  localparam int UC = 8;
  localparam int CH = 2;
  localparam int GU = 4;
  logic clk = 1'b0, reset = 1'b1, send = 1'b0;
  logic [31:0] command = '0;
  logic ready, envelope, ir_out, frame_done;
  int chk_cnt = 0, pass_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];

  nec_ir_tx #(.UNIT_CYCLES(UC), .CARRIER_HALF(CH), .GAP_UNITS(GU)) dut (
    .clk(clk), .reset(reset), .command(command), .send(send),
    .ready(ready), .envelope(envelope), .ir_out(ir_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Each entry is {envelope, ir_out, ready, frame_done} for one cycle after acceptance.
  function automatic void push_seg(input bit mark, input int units);
    for (int p = 0; p < units * UC; p++)
      exp_q.push_back({mark, mark && ((p / CH) % 2 == 0), 1'b0, 1'b0});
  endfunction

  function automatic void build_model(input logic [31:0] cmd, input bit hold);
    exp_q.delete();
    push_seg(1, 16);
    push_seg(0, 8);
    for (int b = 0; b < 32; b++) begin
      push_seg(1, 1);
      push_seg(0, cmd[b] ? 3 : 1);
    end
    push_seg(1, 1);
    exp_q.push_back(4'b0001);
    for (int g = 1; g < GU * UC; g++) exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0010);
    if (hold) exp_q.push_back(4'b1100);
  endfunction

  task automatic capture(input logic [31:0] cmd, input int n, input bit hold, input int spoof_at);
    obs_q.delete();
    @(negedge clk);
    command = cmd;
    send = 1'b1;
    @(posedge clk);
    #1;
    send = hold;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (i == spoof_at) begin
        command = ~cmd;
        send = 1'b1;
      end
      if (i == spoof_at + 24) send = hold;
      obs_q.push_back({envelope, ir_out, ready, frame_done});
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (ready !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_cnt++;
    if (ready !== 1'b1) $display("FAIL %s: ready=%b after %0d cycles, want 1", name, ready, n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      chk_cnt++;
      if ({ready, envelope, ir_out, frame_done} !== 4'b1000)
        $display("FAIL reset_idle cycle %0d: rdy/env/ir/done=%b want 1000", i, {ready, envelope, ir_out, frame_done});
      else pass_cnt++;
    end
  endtask

  task automatic test_frame(input string name, input logic [31:0] cmd, input int spoof_at);
    logic [31:0] word = '0;
    int pos = 192;
    build_model(cmd, 0);
    capture(cmd, exp_q.size(), 0, spoof_at);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL %s cmd=%h cycle %0d: env/ir/rdy/done=%b want %b", name, cmd, i, obs_q[i], exp_q[i]);
      else pass_cnt++;
    end
    for (int b = 0; b < 32 && pos < obs_q.size(); b++) begin
      int z = 0;
      pos += UC;
      while (pos < obs_q.size() && obs_q[pos][3] == 1'b0 && z < 4 * UC) begin
        z++;
        pos++;
      end
      word[b] = z > 2 * UC;
    end
    chk_cnt++;
    if (word !== cmd) $display("FAIL %s decode: got %h want %h", name, word, cmd);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] cmd = $urandom;
    build_model(cmd, 1);
    capture(cmd, exp_q.size(), 1, -100);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL back_to_back cmd=%h cycle %0d: env/ir/rdy/done=%b want %b", cmd, i, obs_q[i], exp_q[i]);
      else pass_cnt++;
    end
    send = 1'b0;
    wait_ready("back_to_back_drain");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    command = 32'h0;
    send = 1'b1;
    @(posedge clk);
    #1;
    send = 1'b0;
    repeat (304) @(posedge clk);
    #1;
    chk_cnt++;
    if ({envelope, ir_out} !== 2'b11) $display("FAIL reset_mid pre: env/ir=%b want 11", {envelope, ir_out});
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    chk_cnt++;
    if ({ready, envelope, ir_out, frame_done} !== 4'b1000)
      $display("FAIL reset_mid async: rdy/env/ir/done=%b want 1000", {ready, envelope, ir_out, frame_done});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_cnt++;
    if ({ready, envelope, ir_out} !== 3'b100) $display("FAIL reset_mid release: rdy/env/ir=%b want 100", {ready, envelope, ir_out});
    else pass_cnt++;
    test_frame("after_reset", $urandom, -100);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({ready, envelope, ir_out, frame_done} !== 4'b1000)
      $display("FAIL in_reset: rdy/env/ir/done=%b want 1000", {ready, envelope, ir_out, frame_done});
    else pass_cnt++;
    reset = 1'b0;
    test_reset();
    test_frame("zero", 32'h0000_0000, -100);
    test_frame("power", 32'hed126b86, -100);
    test_frame("ones", 32'hffff_ffff, -100);
    for (int r = 0; r < 3; r++) test_frame("random", $urandom, -100);
    test_frame("ignore_send", 32'h0000_0000, 200);
    test_frame("ignore_send_rand", $urandom, 330);
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
